// File: rtl/auteur_fifo_ctrl_pkg.sv
// auteur_fifo_ctrl_pkg: shared types and sizing helpers for the arbitrated FIFO controller
package auteur_fifo_ctrl_pkg;
  typedef enum logic [0:0] {RUN, DRAIN} ctrl_state_e;
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/auteur_fifo.sv
// auteur_fifo: unchecked circular storage; the caller guarantees legal push/pop
module auteur_fifo #(
  parameter int DEPTH = 8,
  parameter type dtype = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic push_i,
  input  dtype data_i,
  input  logic pop_i,
  output dtype data_o
);
  localparam int AW = $clog2(DEPTH);
  dtype mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  // read/write pointers wrap at DEPTH-1 so any depth works
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop_i) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
  end
  // storage array, written on push
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_q] <= data_i;
  end
  assign data_o = mem[rd_q];
endmodule

// File: rtl/auteur_rr_arb.sv
// auteur_rr_arb: round-robin one-hot arbiter whose only state is the priority pointer
module auteur_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0] ptr_q, idx, nxt_ptr;
  // scan from lowest to highest priority so the nearest requester after the pointer wins
  always_comb begin
    gnt_o = '0;
    idx = '0;
    nxt_ptr = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (en_i && req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        nxt_ptr = (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
  // pointer moves past the winner only when its push is accepted
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else if (advance_i) ptr_q <= nxt_ptr;
  end
endmodule

// File: rtl/auteur_fifo_arb_ctrl.sv
// auteur_fifo_arb_ctrl: round-robin producers into one FIFO with occupancy flags and drain/flush control
module auteur_fifo_arb_ctrl
  import auteur_fifo_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DEPTH = 8,
  parameter type dtype = logic,
  parameter int ALMOST_FULL = DEPTH - 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      drain_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  dtype                      req_data_i [NUM_REQ],
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output dtype                      out_data_o,
  input  logic                      out_ready_i,
  output logic [count_w(DEPTH)-1:0] count_o,
  output logic                      empty_o,
  output logic                      full_o,
  output logic                      almost_full_o,
  output logic                      drain_done_o
);
  localparam int CW = count_w(DEPTH);
  ctrl_state_e state_q;
  logic [CW-1:0] count_q;
  logic push_en, push, pop;
  dtype push_data;
  // full blocks pushes even with a concurrent pop, keeping out_ready_i off the ready path
  assign push_en = state_q == RUN && count_q < CW'(DEPTH) && !flush_i && !rst_i;
  assign push = |req_ready_o;
  assign out_valid_o = count_q != '0 && !flush_i && !rst_i;
  assign pop = out_valid_o && out_ready_i;
  assign drain_done_o = state_q == DRAIN && count_q == '0 && !flush_i && !rst_i;
  assign count_o = count_q;
  assign empty_o = count_q == '0;
  assign full_o = count_q == CW'(DEPTH);
  assign almost_full_o = count_q >= CW'(ALMOST_FULL);
  auteur_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_valid_i),
    .en_i      (push_en),
    .advance_i (push),
    .gnt_o     (req_ready_o)
  );
  // select the granted producer's payload
  always_comb begin
    push_data = req_data_i[0];
    for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) push_data = req_data_i[i];
  end
  auteur_fifo #(.DEPTH(DEPTH), .dtype(dtype)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (flush_i | rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (out_data_o)
  );
  // occupancy and run/drain sequencing; flush wins over drain and cancels it silently
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      state_q <= RUN;
    end else if (flush_i) begin
      count_q <= '0;
      state_q <= RUN;
    end else begin
      count_q <= count_q + CW'(push) - CW'(pop);
      state_q <= (state_q == RUN) ? (drain_i ? DRAIN : RUN) : (count_q == '0 ? RUN : DRAIN);
    end
  end
endmodule

// File: tb/tb_auteur_fifo_arb_ctrl.sv
// tb_auteur_fifo_arb_ctrl: directed table plus randomized run against a queue-based reference
module tb_auteur_fifo_arb_ctrl;
  localparam int N = 4;
  localparam int D = 8;
  localparam int AF = D - 2;
  typedef logic [7:0] byte_t;
  typedef struct {
    logic r, f, dr;
    logic [N-1:0] v;
    logic o;
    logic [N-1:0] e_rdy;
    int e_cnt;
    logic e_ov, e_dd;
  } vec_t;

  logic clk = 1'b0;
  logic rst, flush, drain, ordy;
  logic [N-1:0] valid, rdy;
  byte_t data [N];
  byte_t odata;
  logic ov, empty, full, af, dd;
  logic [3:0] cnt;

  byte_t q[$];
  int ptr = 0;
  bit draining = 0;
  int pass_cnt = 0;
  int total = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  auteur_fifo_arb_ctrl #(.NUM_REQ(N), .DEPTH(D), .dtype(byte_t), .ALMOST_FULL(AF)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .drain_i       (drain),
    .req_valid_i   (valid),
    .req_data_i    (data),
    .req_ready_o   (rdy),
    .out_valid_o   (ov),
    .out_data_o    (odata),
    .out_ready_i   (ordy),
    .count_o       (cnt),
    .empty_o       (empty),
    .full_o        (full),
    .almost_full_o (af),
    .drain_done_o  (dd)
  );

  function automatic logic [N-1:0] m_rdy();
    if (rst || flush || draining || q.size() >= D) return '0;
    for (int i = 0; i < N; i++) if (valid[(ptr + i) % N]) return N'(1) << ((ptr + i) % N);
    return '0;
  endfunction

  function automatic logic m_ov();
    return q.size() != 0 && !rst && !flush;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic add(input logic r, f, dr, input logic [N-1:0] v, input logic o,
                     input logic [N-1:0] er, input int ec, input logic eov, edd);
    tbl.push_back('{r, f, dr, v, o, er, ec, eov, edd});
  endtask

  task automatic drive(input logic r, f, dr, input logic [N-1:0] v, input logic o);
    @(negedge clk);
    rst = r; flush = f; drain = dr; valid = v; ordy = o;
    for (int i = 0; i < N; i++) data[i] = byte_t'($urandom);
    #1;
  endtask

  task automatic m_update();
    logic [N-1:0] g;
    int sz;
    g = m_rdy();
    sz = q.size();
    if (rst) begin
      q.delete(); ptr = 0; draining = 0;
    end else if (flush) begin
      q.delete(); draining = 0;
    end else begin
      if (m_ov() && ordy) void'(q.pop_front());
      for (int i = 0; i < N; i++) if (g[i]) begin q.push_back(data[i]); ptr = (i + 1) % N; end
      draining = draining ? (sz != 0) : drain;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ready"}, 32'(rdy), 32'(m_rdy()));
    chk({tag, " out_valid"}, 32'(ov), 32'(m_ov()));
    if (m_ov()) chk({tag, " out_data"}, 32'(odata), 32'(q[0]));
    chk({tag, " count"}, 32'(cnt), 32'(q.size()));
    chk({tag, " empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, " full"}, 32'(full), 32'(q.size() == D));
    chk({tag, " almost_full"}, 32'(af), 32'(q.size() >= AF));
    chk({tag, " drain_done"}, 32'(dd), 32'(draining && q.size() == 0 && !rst && !flush));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; drain = 1'b0; valid = '0; ordy = 1'b0;
    for (int i = 0; i < N; i++) data[i] = '0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 8; k++) add(0, 0, 0, 4'b0100, 0, 4'b0100, k, k != 0, 0);
    add(0, 0, 0, 4'b0100, 0, 4'b0000, 8, 1, 0);
    add(0, 0, 0, 4'b0100, 1, 4'b0000, 8, 1, 0);
    add(0, 0, 0, 4'b0100, 0, 4'b0100, 7, 1, 0);
    add(0, 0, 0, 4'b0000, 1, 4'b0000, 8, 1, 0);
    add(0, 0, 0, 4'b0000, 1, 4'b0000, 7, 1, 0);
    add(0, 0, 0, 4'b0000, 1, 4'b0000, 6, 1, 0);
    add(0, 0, 1, 4'b0000, 0, 4'b0000, 5, 1, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 4'b1111, 1, 4'b0000, 5 - k, 1, 0);
    add(0, 0, 0, 4'b1111, 1, 4'b0000, 0, 0, 1);
    add(0, 0, 0, 4'b1111, 0, 4'b1000, 0, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 4'b0001, 1, 1, 0);
    add(0, 0, 0, 4'b1111, 0, 4'b0010, 2, 1, 0);
    add(0, 0, 0, 4'b1111, 1, 4'b0100, 3, 1, 0);
    add(0, 0, 0, 4'b1111, 1, 4'b1000, 3, 1, 0);
    add(0, 0, 0, 4'b1111, 1, 4'b0001, 3, 1, 0);
    add(0, 0, 0, 4'b1111, 0, 4'b0010, 3, 1, 0);
    add(0, 0, 1, 4'b0000, 0, 4'b0000, 4, 1, 0);
    add(0, 1, 0, 4'b1111, 1, 4'b0000, 4, 0, 0);
    add(0, 0, 0, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 4'b0100, 0, 0, 0);
    add(0, 0, 0, 4'b0000, 1, 4'b0000, 1, 1, 0);
    add(0, 0, 1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    add(0, 0, 0, 4'b1111, 0, 4'b0000, 0, 0, 1);
    add(0, 0, 0, 4'b1111, 0, 4'b1000, 0, 0, 0);
    for (int k = 0; k < 5; k++) add(0, 0, 0, 4'b1111, 0, 4'(1 << (k % 4)), k + 1, 1, 0);
    add(1, 0, 0, 4'b1111, 0, 4'b0000, 6, 0, 0);
    add(0, 0, 0, 4'b1010, 0, 4'b0010, 0, 0, 0);
    foreach (tbl[k]) begin
      drive(tbl[k].r, tbl[k].f, tbl[k].dr, tbl[k].v, tbl[k].o);
      chk($sformatf("tbl[%0d] ready", k), 32'(rdy), 32'(tbl[k].e_rdy));
      chk($sformatf("tbl[%0d] count", k), 32'(cnt), 32'(tbl[k].e_cnt));
      chk($sformatf("tbl[%0d] out_valid", k), 32'(ov), 32'(tbl[k].e_ov));
      chk($sformatf("tbl[%0d] drain_done", k), 32'(dd), 32'(tbl[k].e_dd));
      chk($sformatf("tbl[%0d] flags", k), {29'd0, empty, full, af},
          {29'd0, tbl[k].e_cnt == 0, tbl[k].e_cnt == D, tbl[k].e_cnt >= AF});
      if (tbl[k].e_ov && q.size() != 0) chk($sformatf("tbl[%0d] out_data", k), 32'(odata), 32'(q[0]));
      @(posedge clk);
      m_update();
    end
    for (int k = 0; k < 12; k++) begin
      int exp_port;
      exp_port = ptr;
      drive(0, 0, 0, 4'b1111, 1);
      chk($sformatf("fair[%0d] grant", k), 32'(rdy), 32'(1 << exp_port));
      chk($sformatf("fair[%0d] count<=1", k), 32'(cnt <= 1), 32'd1);
      check_model($sformatf("fair[%0d]", k));
      @(posedge clk);
      m_update();
    end
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
            N'($urandom), $urandom_range(0, 2) == 0);
      check_model($sformatf("rnd[%0d]", k));
      @(posedge clk);
      m_update();
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/auteur_fifo_arb_ctrl.md
# auteur_fifo_arb_ctrl

Controller that shares one unchecked `auteur_fifo` storage instance between `NUM_REQ` valid/ready producers and a single valid/ready consumer. It owns the occupancy count and the full, empty and almost-full flags, and it generates the FIFO's push, pop and flush strobes. The underlying FIFO never sees an illegal push or pop. Round-robin arbitration picks the producer, and a drain/flush sequencer lets upstream control quiesce or discard the queue.

## Interface
- `NUM_REQ`, 4: number of producers; minimum 1.
- `DEPTH`, 8: FIFO entries; minimum 2, any value (not restricted to powers of two).
- `dtype`, logic: payload type.
- `ALMOST_FULL`, DEPTH-2: `almost_full_o` threshold; range 1..DEPTH.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discard all queued entries.
- `drain_i` in 1: stop accepting new entries, empty the queue, then resume.
- `req_valid_i` in NUM_REQ: producer valid, one bit per producer.
- `req_data_i` in NUM_REQ×dtype: producer payloads.
- `req_ready_o` out NUM_REQ: producer ready; at most one bit high in any cycle.
- `out_valid_o` out 1: head entry is valid.
- `out_data_o` out dtype: head entry payload.
- `out_ready_i` in 1: consumer accepts the head entry.
- `count_o` out $clog2(DEPTH+1): current occupancy.
- `empty_o`, `full_o`, `almost_full_o` out 1 each: occupancy flags.
- `drain_done_o` out 1: one-cycle pulse when a drain completes.

## Operation
- **FSM states** (`ctrl_state_e`):
  - RUN: accept pushes and pops.
  - DRAIN: pops only; all `req_ready_o` forced to 0.
- **Transitions:**
  - RUN→DRAIN when `drain_i` is high and `flush_i` is low.
  - DRAIN→RUN when `count_q==0`. `drain_done_o` is high in that same cycle.
  - DRAIN→RUN when `flush_i` is high. No `drain_done_o` pulse in this case.
  - `drain_i` is ignored while already in DRAIN.
- **Push rule:**
  - Push is possible only in RUN with `count_q<DEPTH`, `flush_i` low and `rst_i` low.
  - The arbiter grants one requester among those asserting `req_valid_i`. `req_ready_o[g]` goes high and the FIFO push strobe fires with `req_data_i[g]`.
  - `req_ready_o` never depends on `req_valid_i` of other ports or on `out_ready_i` except through the grant.
  - No push into a full queue, even when a pop happens in the same cycle. This avoids a combinational path from `out_ready_i` to `req_ready_o`.
- **Round-robin:**
  - Priority pointer starts at 0.
  - After an accepted push from port g, the pointer moves to (g+1) mod NUM_REQ.
  - With no push, the pointer holds.
- **Pop rule:**
  - `out_valid_o` = (`count_q!=0`) && !`flush_i` && !`rst_i`.
  - Pop fires when `out_valid_o` && `out_ready_i`.
  - `out_data_o` is the FIFO head and is valid only while `out_valid_o` is high.
- **Count:**
  - `count_d` = `count_q` + push − pop.
  - Simultaneous push and pop leaves the count unchanged.
  - Flush sets the count to 0.
- **Flags** (all derived from `count_q`, registered):
  - `empty_o` = `count_q==0`.
  - `full_o` = `count_q==DEPTH`.
  - `almost_full_o` = `count_q>=ALMOST_FULL`.
- **Flush:** takes effect in the cycle `flush_i` is high.
  - Readies and `out_valid_o` are low in that cycle.
  - The FIFO flush strobe is driven.
  - Count and FIFO pointers clear at the edge.
  - The round-robin pointer is not reset.
  - `flush_i` has priority over `drain_i`.
- **Reset:** while `rst_i` is high:
  - `req_ready_o=0`, `out_valid_o=0`.
  - FIFO flush strobe is asserted.
  - At the edge: count=0, state=RUN, RR pointer=0.
  - After reset: `empty_o=1`, `full_o=0`, `almost_full_o=0`, `drain_done_o=0`, `count_o=0`.
  - Reset during DRAIN aborts the drain with no pulse.

## Timing
- Push to visible: an entry accepted at edge N is reflected in `count_o` and `out_valid_o` in cycle N+1.
- Pop effect: `count_o` decrements in the cycle after the pop.
- `out_data_o` shows the next entry in the cycle after the pop.
- Drain on an empty queue:
  - `drain_i` high in cycle N.
  - Cycle N+1: DRAIN with `drain_done_o=1`.
  - Cycle N+2: RUN.
- Combinational paths:
  - `req_valid_i`→`req_ready_o` (arbiter).
  - `out_ready_i`→FIFO pop.
  - `flush_i`/`rst_i`→readies and `out_valid_o`.
  - No other paths.

## Structure
- Package `auteur_fifo_ctrl_pkg` holds:
  - `ctrl_state_e` (RUN, DRAIN).
  - The helper for the count width, `$clog2(DEPTH+1)`.
- Sub-module `auteur_rr_arb`: parameter NUM_REQ; ports `req_i`, `gnt_o` (one-hot), `en_i`, `advance_i`; state is the priority pointer only.
- Storage is one `auteur_fifo` instance with DEPTH and dtype.
  - FIFO flush = `flush_i` | `rst_i`.
  - The FIFO's own reset is tied inactive, because the FIFO reset is asynchronous active-low.

## Test plan
- **Fairness:** NUM_REQ=4, all valid continuously, consumer always ready. Required: grant order 0,1,2,3,0,…; count stays ≤1; data out in grant order.
- **Fill and backpressure:** DEPTH=8, consumer not ready, port 2 valid. Required: 8 accepts; `full_o=1`, `count_o=8`, `req_ready_o=0`. Then one pop: `count_o=7` and one accept the following cycle.
- **Simultaneous push and pop at count=3:** Required: count stays 3; FIFO order preserved; push at full with a concurrent pop is not granted.
- **Drain:** queue holds 5, `drain_i` pulsed, valids held high. Required: no accepts; 5 pops; `drain_done_o` pulses one cycle when count reaches 0; accepts resume the next cycle.
- **Flush mid-drain:** at count=4, `flush_i`. Required: `out_valid_o` low that cycle; next cycle `count_o=0`, `empty_o=1`, RUN, no `drain_done_o` pulse.
- **Reset mid-operation:** at count=6 with pushes active, `rst_i` for 1 cycle. Required: readies 0 during reset; afterwards count 0, `empty_o=1`, the first grant goes to the lowest valid port from pointer 0.
